amm_mem_slave: RTL

Synthesizable Avalon-MM burst slave: on-chip RAM with configurable read latency and pseudo-random waitrequest stalls. Sits directly downstream of mem_checker's memory port and consumes its read/write bursts. Used as the memory endpoint in FPGA self-test builds and as a deterministic DUT partner in simulation. Reports master protocol violations through a sticky error flag.

---
 rtl/amm_mem_slave_pkg.sv | 22 ++
 rtl/rtl_settings_pkg.sv | 6 +
 rtl/amm_rd_delay_line.sv | 38 +++
 rtl/amm_mem_slave.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/amm_mem_slave_pkg.sv
// Types, LFSR definition and parameter checks for amm_mem_slave.
package amm_mem_slave_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    // Fibonacci x^16+x^14+x^13+x^11+1, right-shifting form: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int RD_LAT_MIN = 2;
    localparam int RD_LAT_MAX = 16;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    function automatic bit rd_latency_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction
endpackage

// File: rtl/rtl_settings_pkg.sv
// Bus widths shared by the mem_checker / amm_mem_slave pair.
package rtl_settings_pkg;
    localparam int AMM_ADDR_W  = 31;
    localparam int AMM_DATA_W  = 128;
    localparam int AMM_BURST_W = 11;
endpackage

// File: rtl/amm_rd_delay_line.sv
// Valid/data shift register that delays RAM read results by DEPTH cycles.
// Data stages load only behind a valid beat, so the output holds between bursts.
module amm_rd_delay_line #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], valid_i};
        end
    end

    always_ff @(posedge clk) begin
        if (valid_i) begin
            data_q[0] <= data_i;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (valid_q[i-1]) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
endmodule

// File: rtl/amm_mem_slave.sv
// Avalon-MM burst slave backed by on-chip RAM, with fixed read latency,
// LFSR-driven waitrequest stalls and a sticky protocol-error flag.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a command; single-beat writes complete here
// ST_WRITE | collecting beats 1..N-1 of a write burst
// ST_READ  | issuing reads into the delay line and draining returned beats
module amm_mem_slave
    import amm_mem_slave_pkg::*;
#(
    parameter int          AMM_ADDR_W   = rtl_settings_pkg::AMM_ADDR_W,
    parameter int          AMM_DATA_W   = rtl_settings_pkg::AMM_DATA_W,
    parameter int          AMM_BURST_W  = rtl_settings_pkg::AMM_BURST_W,
    parameter int          MEM_ADDR_W   = 8,
    parameter int          READ_LATENCY = 4,
    parameter bit          STALL_EN     = 1'b1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                     clk_mem_i,
    input  logic                     rst_mem_n_i,
    input  logic [AMM_ADDR_W-1:0]    address_i,
    input  logic                     read_i,
    input  logic                     write_i,
    input  logic [AMM_DATA_W-1:0]    writedata_i,
    input  logic [AMM_DATA_W/8-1:0]  byteenable_i,
    input  logic [AMM_BURST_W-1:0]   burstcount_i,
    output logic                     waitrequest_o,
    output logic                     readdatavalid_o,
    output logic [AMM_DATA_W-1:0]    readdata_o,
    output logic                     err_o
);
    localparam int BE_W  = AMM_DATA_W / 8;
    localparam int DEPTH = 2 ** MEM_ADDR_W;
    localparam logic [AMM_BURST_W-1:0] BC_ONE = AMM_BURST_W'(1);

    if (!rd_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("amm_mem_slave: READ_LATENCY must be within 2..16");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("amm_mem_slave: LFSR_SEED must be non-zero");
    end

    state_t                  state_q, state_d;
    logic [15:0]             lfsr_q;
    logic                    stall, accept;
    logic [AMM_BURST_W-1:0]  cmd_len;
    logic [MEM_ADDR_W-1:0]   wr_addr_q, rd_addr_q, mem_waddr;
    logic [AMM_BURST_W-1:0]  wr_left_q, rd_issue_q, rd_out_q;
    logic                    mem_we, wr_start, wr_beat, rd_start, rd_issue;
    logic                    err_q, err_set, rd_loaded_q;
    logic                    dl_valid;
    logic [AMM_DATA_W-1:0]   dl_data;
    logic [AMM_DATA_W-1:0]   mem [DEPTH];
    logic                    unused_addr;

    assign unused_addr = ^address_i[AMM_ADDR_W-1:MEM_ADDR_W];

    assign stall         = STALL_EN & lfsr_q[0];
    assign waitrequest_o = stall | (state_q == ST_READ) | ~rst_mem_n_i;
    assign accept        = (read_i | write_i) & ~waitrequest_o;
    assign cmd_len       = (burstcount_i == '0) ? BC_ONE : burstcount_i;
    assign rd_issue      = (state_q == ST_READ) && (rd_issue_q != '0);

    always_ff @(posedge clk_mem_i or negedge rst_mem_n_i) begin
        if (!rst_mem_n_i) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_next(lfsr_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_waddr = address_i[MEM_ADDR_W-1:0];
        wr_start  = 1'b0;
        wr_beat   = 1'b0;
        rd_start  = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && write_i) begin
                    // write wins over a simultaneous read
                    mem_we   = 1'b1;
                    wr_start = 1'b1;
                    err_set  = read_i || (burstcount_i == '0);
                    if (burstcount_i > BC_ONE) begin
                        state_d = ST_WRITE;
                    end
                end else if (accept) begin
                    rd_start = 1'b1;
                    err_set  = (burstcount_i == '0);
                    state_d  = ST_READ;
                end
            end
            ST_WRITE: begin
                mem_waddr = wr_addr_q;
                err_set   = read_i;
                if (write_i && !waitrequest_o) begin
                    mem_we  = 1'b1;
                    wr_beat = 1'b1;
                    if (wr_left_q == BC_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (dl_valid && (rd_out_q == BC_ONE)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst bookkeeping: addresses wrap modulo the RAM depth, counts run down to one.
    always_ff @(posedge clk_mem_i or negedge rst_mem_n_i) begin
        if (!rst_mem_n_i) begin
            wr_addr_q  <= '0;
            wr_left_q  <= '0;
            rd_addr_q  <= '0;
            rd_issue_q <= '0;
            rd_out_q   <= '0;
        end else begin
            if (wr_start) begin
                wr_addr_q <= address_i[MEM_ADDR_W-1:0] + MEM_ADDR_W'(1);
                wr_left_q <= cmd_len - BC_ONE;
            end else if (wr_beat) begin
                wr_addr_q <= wr_addr_q + MEM_ADDR_W'(1);
                wr_left_q <= wr_left_q - BC_ONE;
            end
            if (rd_start) begin
                rd_addr_q  <= address_i[MEM_ADDR_W-1:0];
                rd_issue_q <= cmd_len;
                rd_out_q   <= cmd_len;
            end else begin
                if (rd_issue) begin
                    rd_addr_q  <= rd_addr_q + MEM_ADDR_W'(1);
                    rd_issue_q <= rd_issue_q - BC_ONE;
                end
                if (dl_valid && (state_q == ST_READ)) begin
                    rd_out_q <= rd_out_q - BC_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_mem_i or negedge rst_mem_n_i) begin
        if (!rst_mem_n_i) begin
            err_q       <= 1'b0;
            rd_loaded_q <= 1'b0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (dl_valid) begin
                rd_loaded_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_mem_i) begin
        if (mem_we) begin
            for (int j = 0; j < BE_W; j++) begin
                if (byteenable_i[j]) begin
                    mem[mem_waddr][8*j +: 8] <= writedata_i[8*j +: 8];
                end
            end
        end
    end

    amm_rd_delay_line #(
        .DEPTH  (READ_LATENCY),
        .DATA_W (AMM_DATA_W)
    ) u_rd_delay (
        .clk     (clk_mem_i),
        .rst_n   (rst_mem_n_i),
        .valid_i (rd_issue),
        .data_i  (mem[rd_addr_q]),
        .valid_o (dl_valid),
        .data_o  (dl_data)
    );

    // Until the first beat after reset the delay-line data is undefined; show zero.
    assign readdatavalid_o = dl_valid;
    assign readdata_o      = (rd_loaded_q || dl_valid) ? dl_data : '0;
    assign err_o           = err_q;
endmodule
